// File: rtl/pu_io_req_issue.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | pu_io_req_issue : single-outstanding PU load/store issuer with worst-case |
// | ack latency tracking. Optional ack timeout: define PU_IO_TIMEOUT_EN.      |
// | Rev 1.0                                                                   |
// +--------------------------------------------------------------------------+
module pu_io_req_issue #(
  parameter int WIDTH_NBITS = 32,
  parameter int ADDR_NBITS  = 16,
  parameter int FID_NBITS   = 8,
  parameter int LAT_NBITS   = 8,
  parameter int TIMEOUT     = 255,
  localparam int CMD_NBITS  = ADDR_NBITS + FID_NBITS + 1 + WIDTH_NBITS
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   pu_req_i,
  input  logic                   pu_wr_i,
  input  logic [ADDR_NBITS-1:0]  pu_addr_i,
  input  logic [FID_NBITS-1:0]   pu_fid_i,
  input  logic [WIDTH_NBITS-1:0] pu_wdata_i,
  output logic                   pu_rdy_o,
  output logic                   pu_ack_o,
  output logic [WIDTH_NBITS-1:0] pu_rdata_o,
  output logic                   pu_err_o,
  output logic                   io_req_o,
  output logic [CMD_NBITS-1:0]   io_cmd_o,     // {addr, fid, wr, wdata}
  input  logic                   io_ack_i,
  input  logic [WIDTH_NBITS-1:0] io_ack_data_i,
  output logic [LAT_NBITS-1:0]   lat_max_o,
  input  logic                   lat_clr_i,
  output logic                   spur_ack_o
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2
  } state_e;

  state_e                 state_q;
  logic                   io_req_q;
  logic [CMD_NBITS-1:0]   io_cmd_q;
  logic                   pu_ack_q;
  logic [WIDTH_NBITS-1:0] pu_rdata_q;
  logic [LAT_NBITS-1:0]   cnt_q;
  logic [LAT_NBITS-1:0]   lat_max_q;
  logic [LAT_NBITS-1:0]   lat_max_d;
  logic                   spur_q;
  logic                   w_ack_done;
  logic                   w_to_done;

  if (TIMEOUT >= (1 << LAT_NBITS)) begin : g_timeout_range_chk
    $error("TIMEOUT must fit in LAT_NBITS");
  end

  // The completion cycle is not offered to the core: it is consuming pu_ack,
  // which spaces back-to-back accesses at one per four cycles.
  assign pu_rdy_o   = (state_q == S_IDLE) && !pu_ack_q;
  assign pu_ack_o   = pu_ack_q;
  assign pu_rdata_o = pu_rdata_q;
  assign io_req_o   = io_req_q;
  assign io_cmd_o   = io_cmd_q;
  assign lat_max_o  = lat_max_q;
  assign spur_ack_o = spur_q;

  assign w_ack_done = (state_q == S_WAIT) && io_ack_i;

`ifdef PU_IO_TIMEOUT_EN
  localparam logic [LAT_NBITS-1:0] C_TIMEOUT = LAT_NBITS'(TIMEOUT);
  logic pu_err_q;
  assign pu_err_o  = pu_err_q;
  assign w_to_done = (state_q == S_WAIT) && !io_ack_i && (cnt_q == C_TIMEOUT);
`else
  assign pu_err_o  = 1'b0;
  assign w_to_done = 1'b0;
`endif

  always_comb begin
    lat_max_d = lat_max_q;
    if (lat_clr_i) begin
      lat_max_d = '0;
    end else if ((w_ack_done || w_to_done) && (cnt_q > lat_max_q)) begin
      lat_max_d = cnt_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      io_req_q   <= 1'b0;
      io_cmd_q   <= '0;
      pu_ack_q   <= 1'b0;
      pu_rdata_q <= '0;
      cnt_q      <= '0;
      lat_max_q  <= '0;
      spur_q     <= 1'b0;
`ifdef PU_IO_TIMEOUT_EN
      pu_err_q   <= 1'b0;
`endif
    end else begin
      io_req_q   <= 1'b0;
      pu_ack_q   <= 1'b0;
      pu_rdata_q <= '0;
`ifdef PU_IO_TIMEOUT_EN
      pu_err_q   <= 1'b0;
`endif
      lat_max_q  <= lat_max_d;
      if (io_ack_i && (state_q != S_WAIT)) begin
        spur_q <= 1'b1;
      end
      case (state_q)
        S_IDLE: begin
          if (pu_req_i && pu_rdy_o) begin
            state_q  <= S_ISSUE;
            io_req_q <= 1'b1;
            io_cmd_q <= {pu_addr_i, pu_fid_i, pu_wr_i, pu_wdata_i};
          end
        end
        S_ISSUE: begin
          state_q <= S_WAIT;
          cnt_q   <= LAT_NBITS'(1);
        end
        S_WAIT: begin
          if (w_ack_done) begin
            state_q    <= S_IDLE;
            pu_ack_q   <= 1'b1;
            pu_rdata_q <= io_cmd_q[WIDTH_NBITS] ? '0 : io_ack_data_i;
          end else if (w_to_done) begin
            state_q  <= S_IDLE;
            pu_ack_q <= 1'b1;
`ifdef PU_IO_TIMEOUT_EN
            pu_err_q <= 1'b1;
`endif
          end else if (cnt_q != '1) begin
            cnt_q <= cnt_q + LAT_NBITS'(1);
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_pu_io_req_issue.sv
`default_nettype none
// Bench for pu_io_req_issue: vector table, multi-cycle corner sequences and
// randomized accesses against a delay-based latency/spurious-ack model.
module tb_pu_io_req_issue;

  localparam int W   = 16;
  localparam int A   = 16;
  localparam int F   = 4;
  localparam int L   = 8;
  localparam int TO  = 10;
  localparam int CW  = A + F + 1 + W;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          pu_req_i = 1'b0;
  logic          pu_wr_i = 1'b0;
  logic [A-1:0]  pu_addr_i = '0;
  logic [F-1:0]  pu_fid_i = '0;
  logic [W-1:0]  pu_wdata_i = '0;
  logic          pu_rdy_o;
  logic          pu_ack_o;
  logic [W-1:0]  pu_rdata_o;
  logic          pu_err_o;
  logic          io_req_o;
  logic [CW-1:0] io_cmd_o;
  logic          io_ack_i = 1'b0;
  logic [W-1:0]  io_ack_data_i = '0;
  logic [L-1:0]  lat_max_o;
  logic          lat_clr_i = 1'b0;
  logic          spur_ack_o;

  pu_io_req_issue #(
    .WIDTH_NBITS(W), .ADDR_NBITS(A), .FID_NBITS(F), .LAT_NBITS(L), .TIMEOUT(TO)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .pu_req_i(pu_req_i), .pu_wr_i(pu_wr_i), .pu_addr_i(pu_addr_i),
    .pu_fid_i(pu_fid_i), .pu_wdata_i(pu_wdata_i),
    .pu_rdy_o(pu_rdy_o), .pu_ack_o(pu_ack_o), .pu_rdata_o(pu_rdata_o),
    .pu_err_o(pu_err_o), .io_req_o(io_req_o), .io_cmd_o(io_cmd_o),
    .io_ack_i(io_ack_i), .io_ack_data_i(io_ack_data_i),
    .lat_max_o(lat_max_o), .lat_clr_i(lat_clr_i), .spur_ack_o(spur_ack_o)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;
  int lat_model = 0;
  bit spur_model = 1'b0;

  typedef struct {
    bit           wr;
    logic [A-1:0] addr;
    logic [F-1:0] fid;
    logic [W-1:0] wdata;
    int           dly;
    logic [W-1:0] adata;
    bit           clr;
    logic [W-1:0] exp_rdata;
    logic [L-1:0] exp_lat;
  } vec_t;

  vec_t vecs[6];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic int lat_after(input int dly, input bit clr);
    int d;
    d = (dly > 255) ? 255 : dly;
    if (clr) return 0;
    return (d > lat_model) ? d : lat_model;
  endfunction

  // One access whose io_ack arrives dly cycles after io_req.
  task automatic do_access(input bit wr, input logic [A-1:0] addr, input logic [F-1:0] fid,
                           input logic [W-1:0] wdata, input int dly, input logic [W-1:0] adata,
                           input bit clr, input logic [W-1:0] exp_rdata, input logic [L-1:0] exp_lat);
    logic [CW-1:0] exp_cmd;
    int waited;
    exp_cmd = {addr, fid, wr, wdata};
    waited = 0;
    while (!pu_rdy_o && waited < 20) begin
      step();
      waited++;
    end
    check("rdy_before_req", pu_rdy_o, 1'b1);
    pu_req_i = 1'b1; pu_wr_i = wr; pu_addr_i = addr; pu_fid_i = fid; pu_wdata_i = wdata;
    step();
    pu_req_i = 1'b0; pu_wr_i = 1'($urandom); pu_addr_i = A'($urandom);
    pu_fid_i = F'($urandom); pu_wdata_i = W'($urandom);
    check("io_req_issue", io_req_o, 1'b1);
    check("io_cmd_issue", io_cmd_o, exp_cmd);
    check("rdy_issue", pu_rdy_o, 1'b0);
    for (int d = 1; d <= dly; d++) begin
      step();
      if (d == 1) begin
        check("io_req_wait", io_req_o, 1'b0);
        check("rdy_wait", pu_rdy_o, 1'b0);
        check("ack_early", pu_ack_o, 1'b0);
      end
      if (d == dly) begin
        io_ack_i = 1'b1; io_ack_data_i = adata; lat_clr_i = clr;
      end
    end
    step();
    io_ack_i = 1'b0; lat_clr_i = 1'b0; io_ack_data_i = W'($urandom);
    check("pu_ack", pu_ack_o, 1'b1);
    check("pu_rdata", pu_rdata_o, exp_rdata);
    check("pu_err", pu_err_o, 1'b0);
    check("rdy_ackcyc", pu_rdy_o, 1'b0);
    check("lat_max", lat_max_o, exp_lat);
    check("io_cmd_held", io_cmd_o, exp_cmd);
    step();
    check("pu_ack_pulse", pu_ack_o, 1'b0);
    check("rdy_after", pu_rdy_o, 1'b1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int req_t[$];
    int nack;
    int last_req;
    int n;
    vecs[0] = '{0, 16'h0040, 4'd5, 16'h0000, 2, 16'hA5A5, 0, 16'hA5A5, 8'd2};
    vecs[1] = '{1, 16'h0080, 4'd3, 16'h1234, 1, 16'hFFFF, 0, 16'h0000, 8'd2};
    vecs[2] = '{0, 16'h1FFE, 4'hF, 16'h0000, 5, 16'h0001, 0, 16'h0001, 8'd5};
    vecs[3] = '{1, 16'hFFFF, 4'h0, 16'hFFFF, 3, 16'h5A5A, 0, 16'h0000, 8'd5};
    vecs[4] = '{0, 16'h0000, 4'h1, 16'h0000, 1, 16'h8000, 0, 16'h8000, 8'd5};
    vecs[5] = '{0, 16'h0123, 4'h7, 16'h0000, 3, 16'h0F0F, 1, 16'h0F0F, 8'd0};

    repeat (3) step();
    check("rst_io_req", io_req_o, 1'b0);
    check("rst_io_cmd", io_cmd_o, '0);
    check("rst_pu_ack", pu_ack_o, 1'b0);
    check("rst_lat", lat_max_o, '0);
    check("rst_spur", spur_ack_o, 1'b0);
    #1 rst_n = 1'b1;
    step();
    check("rst_rdy", pu_rdy_o, 1'b1);

    foreach (vecs[i]) begin
      do_access(vecs[i].wr, vecs[i].addr, vecs[i].fid, vecs[i].wdata, vecs[i].dly,
                vecs[i].adata, vecs[i].clr, vecs[i].exp_rdata, vecs[i].exp_lat);
      lat_model = lat_after(vecs[i].dly, vecs[i].clr);
    end

    // Back-to-back loads, pu_req held, each ack one cycle after its io_req.
    pu_req_i = 1'b1; pu_wr_i = 1'b0; pu_addr_i = 16'h0200; pu_fid_i = 4'd2;
    last_req = 0; nack = 0;
    for (int cyc = 0; cyc < 20; cyc++) begin
      step();
      io_ack_i = last_req[0]; io_ack_data_i = 16'h00C3;
      last_req = int'(io_req_o);
      if (io_req_o) req_t.push_back(cyc);
      if (pu_ack_o) nack++;
      if (cyc == 10) pu_req_i = 1'b0;
    end
    io_ack_i = 1'b0;
    check("b2b_nreq", req_t.size(), 3);
    check("b2b_nack", nack, 3);
    for (int i = 1; i < req_t.size(); i++) check("b2b_gap", req_t[i] - req_t[i-1], 4);
    lat_model = lat_after(1, 0);
    check("b2b_lat", lat_max_o, lat_model);
    check("b2b_spur", spur_ack_o, 1'b0);

    // io_ack in IDLE is spurious; then lat_clr coincident with a real ack.
    io_ack_i = 1'b1; io_ack_data_i = 16'hDEAD;
    step();
    io_ack_i = 1'b0;
    spur_model = 1'b1;
    check("spur_no_ack", pu_ack_o, 1'b0);
    check("spur_set", spur_ack_o, spur_model);
    do_access(0, 16'h0044, 4'd6, 16'h0, 4, 16'h7777, 1, 16'h7777, 8'd0);
    lat_model = 0;
    check("spur_sticky", spur_ack_o, spur_model);

    // Reset while waiting for an ack.
    pu_req_i = 1'b1; pu_wr_i = 1'b1; pu_addr_i = 16'h0300; pu_fid_i = 4'd9; pu_wdata_i = 16'hBEEF;
    step();
    pu_req_i = 1'b0;
    step(); step();
    #2 rst_n = 1'b0;
    #1;
    lat_model = 0; spur_model = 1'b0;
    check("mid_rst_io_req", io_req_o, 1'b0);
    check("mid_rst_io_cmd", io_cmd_o, '0);
    check("mid_rst_pu_ack", pu_ack_o, 1'b0);
    check("mid_rst_rdata", pu_rdata_o, '0);
    check("mid_rst_err", pu_err_o, 1'b0);
    check("mid_rst_lat", lat_max_o, '0);
    check("mid_rst_spur", spur_ack_o, 1'b0);
    step();
    #2 rst_n = 1'b1;
    step();
    check("post_rst_rdy", pu_rdy_o, 1'b1);
    io_ack_i = 1'b1;
    step();
    io_ack_i = 1'b0;
    spur_model = 1'b1;
    check("post_rst_spur", spur_ack_o, spur_model);
    check("post_rst_no_ack", pu_ack_o, 1'b0);
    do_access(0, 16'h0048, 4'd1, 16'h0, 2, 16'h4242, 0, 16'h4242, L'(lat_after(2, 0)));
    lat_model = lat_after(2, 0);

`ifdef PU_IO_TIMEOUT_EN
    // No ack: completion with error after the TO-th wait cycle.
    pu_req_i = 1'b1; pu_wr_i = 1'b0; pu_addr_i = 16'h0500; pu_fid_i = 4'd4;
    step();
    pu_req_i = 1'b0;
    check("to_io_req", io_req_o, 1'b1);
    n = 0;
    while (!pu_ack_o && n < 40) begin
      step();
      n++;
    end
    lat_model = lat_after(TO, 0);
    check("to_cycles", n, TO + 1);
    check("to_err", pu_err_o, 1'b1);
    check("to_rdata", pu_rdata_o, '0);
    check("to_lat", lat_max_o, lat_model);
    step();
    io_ack_i = 1'b1; io_ack_data_i = 16'h1111;
    step();
    io_ack_i = 1'b0;
    check("to_late_no_ack", pu_ack_o, 1'b0);
    check("to_late_spur", spur_ack_o, 1'b1);
    check("to_late_lat", lat_max_o, lat_model);
`else
    n = 300;
    do_access(0, 16'h0600, 4'd8, 16'h0, n, 16'h6060, 0, 16'h6060, L'(lat_after(n, 0)));
    lat_model = lat_after(n, 0);
`endif

    // Randomized accesses with idle gaps carrying spurious acks and clears.
    for (int t = 0; t < 40; t++) begin
      int gap;
      bit wr, clr;
      int dly;
      logic [W-1:0] ad;
      gap = $urandom_range(0, 2);
      for (int g = 0; g < gap; g++) begin
        if ($urandom_range(0, 5) == 0) begin io_ack_i = 1'b1; spur_model = 1'b1; end
        if ($urandom_range(0, 5) == 0) begin lat_clr_i = 1'b1; lat_model = 0; end
        step();
        io_ack_i = 1'b0; lat_clr_i = 1'b0;
      end
      check("rnd_spur", spur_ack_o, spur_model);
      check("rnd_lat_idle", lat_max_o, lat_model);
      wr  = 1'($urandom);
      clr = ($urandom_range(0, 7) == 0);
      dly = $urandom_range(1, 9);
      ad  = W'($urandom);
      do_access(wr, A'($urandom), F'($urandom), W'($urandom), dly, ad, clr,
                wr ? '0 : ad, L'(lat_after(dly, clr)));
      lat_model = lat_after(dly, clr);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
